// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save sequential accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RES = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    // Enough headroom for n_ops full-scale operands, so no carry is ever lost.
    function automatic int acc_width(input int data_w, input int n_ops);
        return data_w + $clog2(n_ops);
    endfunction

    function automatic int cnt_width(input int n_ops);
        return $clog2(n_ops + 1);
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// One 3:2 carry-save compressor row; the carry word comes out pre-shifted.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W-1:0] co
);

    logic [W-1:0] w_maj;

    assign w_maj = (a & b) | (a & c) | (b & c);
    assign s     = a ^ b ^ c;
    assign co    = w_maj << 1;

endmodule

// File: rtl/csa_seq_accum.sv
// Folds a packet of operands into a sum/carry pair, then resolves it with one
// carry-propagate add and presents the result on the output stream.
module csa_seq_accum
    import csa_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OPS  = 8,
    localparam int ACC_W  = acc_width(DATA_W, N_OPS),
    localparam int CNT_W  = cnt_width(N_OPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_sum,
    output logic [CNT_W-1:0]  m_count,
    output logic              m_err
);

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_s, r_c, r_sum;
    logic [ACC_W-1:0]   w_x, w_s, w_c;
    logic [CNT_W-1:0]   r_cnt, w_cnt_inc;
    logic               r_err;
    logic               w_acc, w_full, w_close, w_ohs;

    assign w_x       = ACC_W'(s_data);
    assign s_ready   = (r_state == ST_ACC) && !rst;
    assign m_valid   = (r_state == ST_OUT);
    assign m_sum     = r_sum;
    assign m_count   = r_cnt;
    assign m_err     = r_err;

    assign w_acc     = s_valid && s_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_full    = (w_cnt_inc == CNT_W'(N_OPS));
    assign w_close   = w_acc && (s_last || w_full);
    assign w_ohs     = m_valid && m_ready;

    csa_3to2 #(.W(ACC_W)) u_csa (
        .a  (r_s),
        .b  (r_c),
        .c  (w_x),
        .s  (w_s),
        .co (w_c)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_close) w_state_nxt = ST_RES;
            ST_RES:  w_state_nxt = ST_OUT;
            ST_OUT:  if (w_ohs) w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_s     <= '0;
            r_c     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_ACC: begin
                    if (w_acc) begin
                        r_s   <= w_s;
                        r_c   <= w_c;
                        r_cnt <= w_cnt_inc;
                        // A close without s_last can only be the forced one at N_OPS.
                        if (w_close) r_err <= ~s_last;
                    end
                end
                ST_RES: r_sum <= r_s + r_c;
                ST_OUT: begin
                    if (w_ohs) begin
                        r_s   <= '0;
                        r_c   <= '0;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_seq_accum.sv
// Scoreboard bench for csa_seq_accum at default parameters.
module tb_csa_seq_accum;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 11;
    localparam int CNT_W  = 4;

    typedef struct {
        int sum;
        int cnt;
        int err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [ACC_W-1:0]  m_sum;
    logic [CNT_W-1:0]  m_count;
    logic              m_err;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t_acc = 0;

    csa_seq_accum u_dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sum   (m_sum),
        .m_count (m_count),
        .m_err   (m_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int sum, input int cnt, input int err);
        exp_t e;
        e.sum = sum; e.cnt = cnt; e.err = err;
        exp_q.push_back(e);
    endtask

    // Present one beat from posedge+1 until accepted; returns stall cycles.
    task automatic send(input int d, input bit last, output int waits);
        s_valid = 1'b1;
        s_data  = DATA_W'(d);
        s_last  = last;
        waits   = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waits++;
            if (waits > 100) begin
                chk("accept_timeout", waits, 0);
                break;
            end
        end
        t_acc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_mvalid(output int lat);
        int n;
        n = 0;
        lat = -1;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                lat = cyc - t_acc;
                break;
            end
            n++;
            if (n > 100) begin
                chk("mvalid_timeout", n, 0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Output monitor: every result handshake pops and compares one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_sum",   int'(m_sum),   e.sum);
                    chk("m_count", int'(m_count), e.cnt);
                    chk("m_err",   int'(m_err),   e.err);
                end
            end
        end
    end

    initial begin
        int w, lat, n;

        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_sum",   int'(m_sum),   0);
        chk("rst_m_count", int'(m_count), 0);
        chk("rst_m_err",   int'(m_err),   0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(s_ready), 1);
        @(posedge clk); #1;

        // 5+7+9, latency from last accept
        push(21, 3, 0);
        send(5, 0, w); send(7, 0, w); send(9, 1, w);
        wait_mvalid(lat);
        chk("latency", lat, 2);

        // full-scale packet fills ACC_W exactly
        push(2040, 8, 0);
        for (int i = 0; i < 8; i++) send(255, i == 7, w);
        wait_mvalid(lat);
        chk("latency_full", lat, 2);

        // forced close; waiting operand starts the next packet
        push(8, 8, 1);
        push(105, 2, 0);
        for (int i = 0; i < 8; i++) send(1, 0, w);
        send(100, 0, w);
        chk("forced_stall", w, 2);
        send(5, 1, w);
        wait_mvalid(lat);

        // single operand
        push(42, 1, 0);
        send(42, 1, w);
        wait_mvalid(lat);

        // back-pressure: output held stable, input blocked
        push(3, 2, 0);
        m_ready = 1'b0;
        send(1, 0, w); send(2, 1, w);
        wait_mvalid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(m_valid), 1);
            chk("hold_sum",   int'(m_sum),   3);
            chk("hold_count", int'(m_count), 2);
            chk("hold_err",   int'(m_err),   0);
            chk("hold_ready", int'(s_ready), 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("ready_during_hs", int'(s_ready), 0);
        @(negedge clk);
        chk("ready_after_hs", int'(s_ready), 1);
        @(posedge clk); #1;

        // mid-packet reset discards the partial packet
        send(3, 0, w); send(4, 0, w);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", int'(s_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_m_count", int'(m_count), 0);
        @(posedge clk); #1;
        push(30, 2, 0);
        send(10, 0, w); send(20, 1, w);
        wait_mvalid(lat);
        chk("latency_postrst", lat, 2);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); n++;
        end
        repeat (10) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/csa_seq_accum.md
# csa_seq_accum

Sequential multi-operand accumulator that time-shares one 3:2 carry-save stage over a stream of operands. Each operand accepted on the input stream is folded into a registered sum/carry pair without carry propagation. At end of packet, one carry-propagate add resolves the pair into a binary sum, which is presented on an output stream. It sits between an operand source and any consumer that needs the sum of a variable-length group, replacing a full adder tree where area matters more than throughput.

## Interface
- DATA_W, 8, operand width (unsigned)
- N_OPS, 8, maximum operands per packet (≥1)
- ACC_W, DATA_W + $clog2(N_OPS), accumulator/result width; derived, not overridden
- CNT_W, $clog2(N_OPS+1), operand-count width; derived
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  operand valid
- s_ready  out  1  block accepts operand
- s_data  in  DATA_W  operand
- s_last  in  1  operand is final of packet
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_sum  out  ACC_W  packet sum
- m_count  out  CNT_W  operands in packet
- m_err  out  1  packet force-closed at N_OPS without s_last

## Operation
- FSM states: ACC, RES, OUT. Reset → ACC.
- ACC: s_ready=1. On s_valid&s_ready: S ← S^C^x, C ← (maj(S,C,x) << 1) truncated to ACC_W, where x = zero-extended s_data; count ← count+1.
- Packet closes on accepted beat with s_last=1, or on the beat where count+1 == N_OPS (then err ← ~s_last). Closing beat → RES.
- RES: s_ready=0; sum_reg ← S + C (ACC_W bits, MSB carry discarded); → OUT.
- OUT: m_valid=1; m_sum, m_count, m_err held stable until m_valid&m_ready. On handshake: S, C, count, err ← 0; → ACC.
- Width rule: N_OPS unsigned DATA_W operands fit in ACC_W, so truncating the carry's shifted-out MSB and the final carry loses nothing.
- Operands beyond a forced close are not consumed; they wait (s_ready=0) and start the next packet.
- s_last on a beat that also reaches N_OPS: normal close, m_err=0.

## Timing
- Reset values: s_ready=0 while rst=1; m_valid=0, m_sum=0, m_count=0, m_err=0; S=C=0.
- s_ready=1 in the first cycle after rst deasserts.
- Throughput: one operand per cycle in ACC.
- Latency: closing beat accepted in cycle t → RES in t+1 → m_valid=1 in t+2.
- s_ready=0 from t+1 until the cycle after the output handshake; s_ready=1 in the cycle after m_valid&m_ready.
- Minimum packet period: n+2 cycles for n operands with m_ready held high.
- rst mid-packet or with m_valid pending: all accumulated state and any pending result discarded; no output emitted.
- m_valid never deasserts without handshake except on rst.

## Structure
- Package csa_pkg: state enum type (ACC/RES/OUT), function for ACC_W/CNT_W derivation.
- Sub-module csa_3to2: purely combinational, parameter W, inputs a/b/c, outputs s = a^b^c and co = maj(a,b,c)<<1 truncated to W; instanced once with W=ACC_W. Registers and FSM live in csa_seq_accum.

## Test plan
- Defaults; operands 5, 7, 9, s_last on 9 → m_sum=21, m_count=3, m_err=0, m_valid exactly 2 cycles after last accept.
- Eight operands of 255, s_last on 8th → m_sum=2040 (ACC_W=11), m_count=8, m_err=0; no overflow.
- Eight operands of 1 with s_last never asserted, 9th operand 100 waiting → m_sum=8, m_count=8, m_err=1; 100 is consumed only after handshake and becomes first operand of next packet.
- Single operand 42 with s_last → m_sum=42, m_count=1.
- m_ready held low 5 cycles during OUT → m_sum/m_count/m_err stable, s_ready=0; s_ready=1 the cycle after the handshake.
- rst pulsed for 1 cycle after 2 operands (3, 4) accepted, then packet 10, 20 with s_last → m_sum=30, m_count=2; no output from the aborted packet.
